// File: rtl/array_bank_if.sv
// Request/response bundle for array_bank: one write port, two read ports,
// bulk clear control and status.
interface array_bank_if #(
    parameter int DATLEN    = 12,
    parameter int SIZE_LOG2 = 6
);
    logic                 put;
    logic [SIZE_LOG2-1:0] put_index;
    logic [DATLEN-1:0]    put_val;
    logic                 put_err;
    logic                 get_a;
    logic [SIZE_LOG2-1:0] get_a_index;
    logic [DATLEN-1:0]    get_a_val;
    logic                 get_a_valid;
    logic                 get_b;
    logic [SIZE_LOG2-1:0] get_b_index;
    logic [DATLEN-1:0]    get_b_val;
    logic                 get_b_valid;
    logic                 clear;
    logic                 busy;
    logic [SIZE_LOG2:0]   count;

    modport master (
        output put, put_index, put_val,
        output get_a, get_a_index, get_b, get_b_index, clear,
        input  put_err, get_a_val, get_a_valid,
        input  get_b_val, get_b_valid, busy, count
    );

    modport slave (
        input  put, put_index, put_val,
        input  get_a, get_a_index, get_b, get_b_index, clear,
        output put_err, get_a_val, get_a_valid,
        output get_b_val, get_b_valid, busy, count
    );
endinterface

// File: rtl/array_bank.sv
// Register-file bank with valid bits, two registered read ports,
// one write port and a one-entry-per-cycle bulk clear sweep.
module array_bank #(
    parameter int                DATLEN    = 12,
    parameter int                SIZE      = 64,
    parameter int                SIZE_LOG2 = 6,
    parameter int                BYPASS    = 1,
    parameter logic [DATLEN-1:0] CLEAR_VAL = '0
) (
    input logic         clk,
    input logic         rst,
    array_bank_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [SIZE_LOG2:0]   SIZE_W = (SIZE_LOG2+1)'(SIZE);
    localparam logic [SIZE_LOG2-1:0] LAST   = SIZE_LOG2'(SIZE-1);
    localparam logic [SIZE_LOG2:0]   ONE    = (SIZE_LOG2+1)'(1);

    logic [DATLEN-1:0]    mem [SIZE];
    logic [SIZE-1:0]      vld;
    state_t               state;
    logic [SIZE_LOG2-1:0] ptr;

    logic put_ok, wr, a_ok, b_ok, a_hit, b_hit;

    assign put_ok = {1'b0, bus.put_index} < SIZE_W;
    assign a_ok   = {1'b0, bus.get_a_index} < SIZE_W;
    assign b_ok   = {1'b0, bus.get_b_index} < SIZE_W;
    assign wr     = bus.put && put_ok && (state == IDLE);
    // Same-edge write forwarding only when the new-data policy is selected
    assign a_hit  = (BYPASS != 0) && wr && (bus.put_index == bus.get_a_index);
    assign b_hit  = (BYPASS != 0) && wr && (bus.put_index == bus.get_b_index);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) mem[i] <= CLEAR_VAL;
            vld             <= '0;
            state           <= IDLE;
            ptr             <= '0;
            bus.count       <= '0;
            bus.busy        <= 1'b0;
            bus.put_err     <= 1'b0;
            bus.get_a_val   <= '0;
            bus.get_a_valid <= 1'b0;
            bus.get_b_val   <= '0;
            bus.get_b_valid <= 1'b0;
        end else begin
            bus.put_err <= bus.put && !(put_ok && (state == IDLE));

            if (bus.get_a) begin
                if (!a_ok) begin
                    bus.get_a_val   <= CLEAR_VAL;
                    bus.get_a_valid <= 1'b0;
                end else if (a_hit) begin
                    bus.get_a_val   <= bus.put_val;
                    bus.get_a_valid <= 1'b1;
                end else begin
                    bus.get_a_val   <= mem[bus.get_a_index];
                    bus.get_a_valid <= vld[bus.get_a_index];
                end
            end

            if (bus.get_b) begin
                if (!b_ok) begin
                    bus.get_b_val   <= CLEAR_VAL;
                    bus.get_b_valid <= 1'b0;
                end else if (b_hit) begin
                    bus.get_b_val   <= bus.put_val;
                    bus.get_b_valid <= 1'b1;
                end else begin
                    bus.get_b_val   <= mem[bus.get_b_index];
                    bus.get_b_valid <= vld[bus.get_b_index];
                end
            end

            unique case (state)
                IDLE: begin
                    if (wr) begin
                        mem[bus.put_index] <= bus.put_val;
                        vld[bus.put_index] <= 1'b1;
                        if (!vld[bus.put_index]) bus.count <= bus.count + ONE;
                    end
                    if (bus.clear) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= CLEAR_VAL;
                    vld[ptr] <= 1'b0;
                    if (vld[ptr]) bus.count <= bus.count - ONE;
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_bank.sv
// Randomised bench for array_bank: two instances (new-data and old-data
// policies, full and partial index range) against an array-based model.
module tb_array_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        put, ga, gb, clr;
    logic [5:0]  pidx, gai, gbi;
    logic [11:0] pval;

    array_bank_if #(.DATLEN(12), .SIZE_LOG2(6)) b0 ();
    array_bank_if #(.DATLEN(12), .SIZE_LOG2(6)) b1 ();

    assign b0.put = put;   assign b1.put = put;
    assign b0.put_index = pidx;   assign b1.put_index = pidx;
    assign b0.put_val = pval;   assign b1.put_val = pval;
    assign b0.get_a = ga;   assign b1.get_a = ga;
    assign b0.get_a_index = gai;   assign b1.get_a_index = gai;
    assign b0.get_b = gb;   assign b1.get_b = gb;
    assign b0.get_b_index = gbi;   assign b1.get_b_index = gbi;
    assign b0.clear = clr;   assign b1.clear = clr;

    array_bank #(.BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    array_bank #(.SIZE(48), .BYPASS(0), .CLEAR_VAL(12'h5A5)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    int tests = 0;
    int fails = 0;

    int          sz [2] = '{64, 48};
    bit          bp [2] = '{1'b1, 1'b0};
    logic [11:0] cv [2] = '{12'h000, 12'h5A5};

    logic [11:0] m_mem [2][64];
    bit          m_vld [2][64];
    int          m_sw  [2];
    logic [11:0] m_av  [2];
    logic [11:0] m_bv  [2];
    bit          m_aok [2];
    bit          m_bok [2];
    bit          m_err [2];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int valid_count(int k);
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_vld[k][i]);
        return n;
    endfunction

    task automatic model_read(int k, logic [5:0] idx, bit acc,
                              output logic [11:0] v, output bit ok);
        if (int'(idx) >= sz[k]) begin
            v = cv[k]; ok = 1'b0;
        end else if (bp[k] && acc && idx == pidx) begin
            v = pval; ok = 1'b1;
        end else begin
            v = m_mem[k][idx]; ok = m_vld[k][idx];
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit sweeping, acc;
            if (rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_mem[k][i] = cv[k];
                    m_vld[k][i] = 1'b0;
                end
                m_sw[k] = -1;
                m_av[k] = '0; m_aok[k] = 1'b0;
                m_bv[k] = '0; m_bok[k] = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                sweeping = m_sw[k] >= 0;
                acc = put && (int'(pidx) < sz[k]) && !sweeping;
                m_err[k] = put && !acc;
                if (ga) model_read(k, gai, acc, m_av[k], m_aok[k]);
                if (gb) model_read(k, gbi, acc, m_bv[k], m_bok[k]);
                if (acc) begin
                    m_mem[k][pidx] = pval;
                    m_vld[k][pidx] = 1'b1;
                end
                if (sweeping) begin
                    m_mem[k][m_sw[k]] = cv[k];
                    m_vld[k][m_sw[k]] = 1'b0;
                    m_sw[k]++;
                    if (m_sw[k] == sz[k]) m_sw[k] = -1;
                end else if (clr) begin
                    m_sw[k] = 0;
                end
            end
        end
    endtask

    task automatic compare(int k, logic e, logic bz, logic [6:0] c,
                           logic [11:0] av, logic aok,
                           logic [11:0] bv, logic bok);
        check($sformatf("put_err%0d", k), e, m_err[k]);
        check($sformatf("busy%0d", k), bz, m_sw[k] >= 0);
        check($sformatf("count%0d", k), c, valid_count(k));
        check($sformatf("a_val%0d", k), av, m_av[k]);
        check($sformatf("a_valid%0d", k), aok, m_aok[k]);
        check($sformatf("b_val%0d", k), bv, m_bv[k]);
        check($sformatf("b_valid%0d", k), bok, m_bok[k]);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare(0, b0.put_err, b0.busy, b0.count, b0.get_a_val,
                b0.get_a_valid, b0.get_b_val, b0.get_b_valid);
        compare(1, b1.put_err, b1.busy, b1.count, b1.get_a_val,
                b1.get_a_valid, b1.get_b_val, b1.get_b_valid);
    endtask

    task automatic idle();
        put = 1'b0; ga = 1'b0; gb = 1'b0; clr = 1'b0;
        pidx = '0; gai = '0; gbi = '0; pval = '0;
    endtask

    task automatic fill();
        for (int i = 0; i < 64; i++) begin
            idle();
            put = 1'b1; pidx = 6'(i); pval = 12'($urandom);
            cyc();
        end
        idle();
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) begin
            idle();
            ga = 1'b1; gai = 6'(i);
            gb = 1'b1; gbi = 6'(63 - i);
            cyc();
        end
        idle();
    endtask

    initial begin
        int busy_n;
        int t;
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;

        put = 1'b1; pidx = 6'd5; pval = 12'hABC;
        cyc();
        idle(); ga = 1'b1; gai = 6'd5;
        cyc();
        idle();
        check("wr_rd_val", b0.get_a_val, 12'hABC);
        check("wr_rd_valid", b0.get_a_valid, 1'b1);
        check("wr_rd_count", b0.count, 7'd1);

        put = 1'b1; pidx = 6'd3; pval = 12'h123;
        ga = 1'b1; gai = 6'd3; gb = 1'b1; gbi = 6'd3;
        cyc();
        idle();
        check("bypass_new_a", b0.get_a_val, 12'h123);
        check("bypass_new_b", b0.get_b_valid, 1'b1);
        check("bypass_old_a", b1.get_a_val, 12'h5A5);
        check("bypass_old_b", b1.get_b_valid, 1'b0);

        fill();
        check("fill_count", b0.count, 7'd64);
        check("fill_count_small", b1.count, 7'd48);
        put = 1'b1; pidx = 6'd10; pval = 12'h777;
        cyc();
        idle();
        check("overwrite_count", b0.count, 7'd64);

        clr = 1'b1;
        cyc();
        idle();
        busy_n = int'(b0.busy);
        for (int i = 0; i < 70; i++) begin
            idle();
            if (i == 10) begin
                put = 1'b1; pidx = 6'd7; pval = 12'h0F0;
            end
            cyc();
            if (i == 10) check("sweep_put_err", b0.put_err, 1'b1);
            busy_n += int'(b0.busy);
        end
        idle();
        check("busy_len", busy_n, 64);
        check("sweep_count", b0.count, 7'd0);
        read_all();

        for (int i = 0; i < 400; i++) begin
            put  = ($urandom % 2) == 0;
            pidx = 6'($urandom);
            pval = 12'($urandom);
            ga   = ($urandom % 2) == 0;
            gai  = ($urandom % 3 == 0) ? pidx : 6'($urandom);
            gb   = ($urandom % 2) == 0;
            gbi  = ($urandom % 3 == 0) ? pidx : 6'($urandom);
            clr  = ($urandom % 60) == 0;
            rst  = ($urandom % 200) == 0;
            cyc();
        end
        rst = 1'b0;
        idle();
        t = 0;
        while ((b0.busy || b1.busy) && t < 100) begin
            cyc();
            t++;
        end
        check("sweep_settle", b0.busy | b1.busy, 1'b0);

        fill();
        clr = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 19; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("abort_busy", b0.busy, 1'b0);
        check("abort_count", b0.count, 7'd0);
        put = 1'b1; pidx = 6'd9; pval = 12'h9C3;
        cyc();
        idle();
        check("abort_put_err", b0.put_err, 1'b0);
        check("abort_put_count", b0.count, 7'd1);
        read_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
